// File: rtl/fsb_axil_pkg.sv
// rtl/fsb_axil_pkg.sv - shared FSB packet layouts, opcodes and AXI-Lite widths
package fsb_axil_pkg;

  localparam logic [3:0] op_write     = 4'h1;
  localparam logic [3:0] op_read      = 4'h2;
  localparam logic [3:0] op_read_rsp  = 4'h3;
  localparam logic [3:0] op_write_ack = 4'h4;

  localparam int axil_addr_w = 32;
  localparam int axil_data_w = 32;
  localparam int axil_strb_w = 4;
  localparam int axil_resp_w = 2;

  typedef struct packed {
    logic [3:0]             opcode;
    logic [3:0]             tag;
    logic [axil_strb_w-1:0] wstrb;
    logic [3:0]             rsvd;
    logic [axil_addr_w-1:0] addr;
    logic [axil_data_w-1:0] wdata;
  } req_pkt_t;

  typedef struct packed {
    logic [3:0]             opcode;
    logic [3:0]             tag;
    logic [axil_resp_w-1:0] resp;
    logic [37:0]            zero;
    logic [axil_data_w-1:0] rdata;
  } rsp_pkt_t;

  typedef enum logic [2:0] {
    st_idle,
    st_wr,
    st_wr_b,
    st_rd_a,
    st_rd_r,
    st_rsp
  } state_e;

  function automatic rsp_pkt_t make_rsp(input logic [3:0] op, input logic [3:0] tag,
                                        input logic [axil_resp_w-1:0] resp,
                                        input logic [axil_data_w-1:0] data);
    rsp_pkt_t r;
    r.opcode = op;
    r.tag    = tag;
    r.resp   = resp;
    r.zero   = '0;
    r.rdata  = data;
    return r;
  endfunction

endpackage

// File: rtl/fsb_to_axil_master.sv
// rtl/fsb_to_axil_master.sv - FSB request packets to single AXI-Lite master transactions
module fsb_to_axil_master
  import fsb_axil_pkg::*;
#(
  parameter int fsb_width_p = 80,
  parameter bit write_ack_p = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   fsb_v_i,
  input  logic [fsb_width_p-1:0] fsb_data_i,
  output logic                   fsb_yumi_o,
  output logic                   fsb_v_o,
  output logic [fsb_width_p-1:0] fsb_data_o,
  input  logic                   fsb_ready_i,
  output logic [31:0]            m_axil_awaddr_o,
  output logic                   m_axil_awvalid_o,
  input  logic                   m_axil_awready_i,
  output logic [31:0]            m_axil_wdata_o,
  output logic [3:0]             m_axil_wstrb_o,
  output logic                   m_axil_wvalid_o,
  input  logic                   m_axil_wready_i,
  input  logic [1:0]             m_axil_bresp_i,
  input  logic                   m_axil_bvalid_i,
  output logic                   m_axil_bready_o,
  output logic [31:0]            m_axil_araddr_o,
  output logic                   m_axil_arvalid_o,
  input  logic                   m_axil_arready_i,
  input  logic [31:0]            m_axil_rdata_i,
  input  logic [1:0]             m_axil_rresp_i,
  input  logic                   m_axil_rvalid_i,
  output logic                   m_axil_rready_o,
  output logic [7:0]             err_cnt_o
);

  state_e                 state_q, state_n;
  req_pkt_t               req;
  logic [3:0]             tag_q, tag_n;
  logic                   aw_n, w_n, ar_n, b_n, r_n, fsb_v_n;
  logic [31:0]            awaddr_n, wdata_n, araddr_n;
  logic [3:0]             wstrb_n;
  logic [fsb_width_p-1:0] fsb_data_n;
  logic [7:0]             err_n;
  logic                   unused_rsvd;

  assign req         = fsb_data_i;
  assign unused_rsvd = ^req.rsvd;
  assign fsb_yumi_o  = (state_q == st_idle) && fsb_v_i;

  // Every AXI-facing valid/ready is computed here and registered below, so
  // no AXI input reaches an AXI output within the same cycle.
  always_comb begin
    state_n    = state_q;
    tag_n      = tag_q;
    aw_n       = m_axil_awvalid_o;
    w_n        = m_axil_wvalid_o;
    ar_n       = m_axil_arvalid_o;
    b_n        = m_axil_bready_o;
    r_n        = m_axil_rready_o;
    fsb_v_n    = fsb_v_o;
    awaddr_n   = m_axil_awaddr_o;
    wdata_n    = m_axil_wdata_o;
    wstrb_n    = m_axil_wstrb_o;
    araddr_n   = m_axil_araddr_o;
    fsb_data_n = fsb_data_o;
    err_n      = err_cnt_o;
    unique case (state_q)
      st_idle: begin
        if (fsb_v_i) begin
          tag_n = req.tag;
          if (req.opcode == op_write) begin
            state_n  = st_wr;
            aw_n     = 1'b1;
            w_n      = 1'b1;
            awaddr_n = req.addr;
            wdata_n  = req.wdata;
            wstrb_n  = req.wstrb;
          end else if (req.opcode == op_read) begin
            state_n  = st_rd_a;
            ar_n     = 1'b1;
            araddr_n = req.addr;
          end else if (err_cnt_o != 8'hFF) begin
            err_n = err_cnt_o + 8'd1;
          end
        end
      end
      st_wr: begin
        aw_n = m_axil_awvalid_o && !m_axil_awready_i;
        w_n  = m_axil_wvalid_o && !m_axil_wready_i;
        if (!aw_n && !w_n) begin
          state_n = st_wr_b;
          b_n     = 1'b1;
        end
      end
      st_wr_b: begin
        if (m_axil_bvalid_i) begin
          b_n = 1'b0;
          if (write_ack_p) begin
            state_n    = st_rsp;
            fsb_v_n    = 1'b1;
            fsb_data_n = make_rsp(op_write_ack, tag_q, m_axil_bresp_i, 32'h0);
          end else begin
            state_n = st_idle;
          end
        end
      end
      st_rd_a: begin
        if (m_axil_arready_i) begin
          state_n = st_rd_r;
          ar_n    = 1'b0;
          r_n     = 1'b1;
        end
      end
      st_rd_r: begin
        if (m_axil_rvalid_i) begin
          state_n    = st_rsp;
          r_n        = 1'b0;
          fsb_v_n    = 1'b1;
          fsb_data_n = make_rsp(op_read_rsp, tag_q, m_axil_rresp_i, m_axil_rdata_i);
        end
      end
      st_rsp: begin
        if (fsb_ready_i) begin
          state_n = st_idle;
          fsb_v_n = 1'b0;
        end
      end
      default: state_n = st_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q          <= st_idle;
      tag_q            <= '0;
      m_axil_awvalid_o <= 1'b0;
      m_axil_wvalid_o  <= 1'b0;
      m_axil_arvalid_o <= 1'b0;
      m_axil_bready_o  <= 1'b0;
      m_axil_rready_o  <= 1'b0;
      fsb_v_o          <= 1'b0;
      m_axil_awaddr_o  <= '0;
      m_axil_wdata_o   <= '0;
      m_axil_wstrb_o   <= '0;
      m_axil_araddr_o  <= '0;
      fsb_data_o       <= '0;
      err_cnt_o        <= '0;
    end else begin
      state_q          <= state_n;
      tag_q            <= tag_n;
      m_axil_awvalid_o <= aw_n;
      m_axil_wvalid_o  <= w_n;
      m_axil_arvalid_o <= ar_n;
      m_axil_bready_o  <= b_n;
      m_axil_rready_o  <= r_n;
      fsb_v_o          <= fsb_v_n;
      m_axil_awaddr_o  <= awaddr_n;
      m_axil_wdata_o   <= wdata_n;
      m_axil_wstrb_o   <= wstrb_n;
      m_axil_araddr_o  <= araddr_n;
      fsb_data_o       <= fsb_data_n;
      err_cnt_o        <= err_n;
    end
  end

endmodule
